// File: rtl/mem_pkg.sv
// Shared types and line geometry for the instruction-cache line-refill responder.
// LineWords must match the cache that sits on the other side of the mem_* port.
package mem_pkg;

    localparam int LineWords = 4;
    localparam int LineSize  = 32 * LineWords;
    localparam int BeatBits  = $clog2(LineWords);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        RESP
    } state_t;

    typedef logic [LineSize-1:0] line_t;

endpackage

// File: rtl/word_ram.sv
// Word-wide backing store: synchronous read (1-cycle latency), read-first on collision.
// The read port only updates its output when a read is issued, so the last word stays visible.
module word_ram #(
    parameter int DepthWords = 4096,
    parameter int AddrBits   = $clog2(DepthWords)
) (
    input  logic                i_clk,
    input  logic                i_re,
    input  logic [AddrBits-1:0] i_raddr,
    output logic [31:0]         o_rdata,
    input  logic                i_we,
    input  logic [AddrBits-1:0] i_waddr,
    input  logic [31:0]         i_wdata
);

    logic [31:0] r_mem [DepthWords];
    logic [31:0] r_rdata;

    // NOTE: storage has no reset; clearing a RAM array costs a write port per cycle of reset.
    always_ff @(posedge i_clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Serves cache line refills by assembling LineWords beats from word_ram,
// with WaitStates idle cycles per beat and abort on request drop or address change.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int DepthWords = 4096,
    parameter int AddrBits   = $clog2(DepthWords),
    parameter int WaitStates = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_read_en_i,
    output logic        mem_read_valid_o,
    output line_t       mem_read_data_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    localparam int                  LineBits = AddrBits - BeatBits;
    localparam logic [BeatBits-1:0] LastBeat = BeatBits'(LineWords - 1);
    localparam logic [2:0]          WaitMax  = 3'(WaitStates);

    state_t              r_state, w_state_next;
    logic [LineBits-1:0] r_line, w_req_line;
    logic [BeatBits-1:0] r_beat, w_beat_next, r_cap_idx;
    logic [2:0]          r_wait, w_wait_next;
    logic                r_cap_valid;
    line_t               r_line_buf, r_read_data, w_line_final;
    logic                w_issue, w_latch, w_load_out, w_abort;
    logic [31:0]         w_ram_rdata;
    logic                w_unused;

    assign w_req_line       = mem_addr_i[AddrBits+1:BeatBits+2];
    assign w_abort          = !mem_read_en_i || (w_req_line != r_line);
    assign mem_read_valid_o = (r_state == RESP) && !w_abort;
    assign mem_read_data_o  = r_read_data;
    assign w_unused = &{1'b0, mem_addr_i[31:AddrBits+2], mem_addr_i[BeatBits+1:0],
                        wr_addr_i[31:AddrBits+2], wr_addr_i[1:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_wait_next  = r_wait;
        w_issue      = 1'b0;
        w_latch      = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read_en_i) begin
                    w_latch      = 1'b1;
                    w_beat_next  = '0;
                    w_wait_next  = '0;
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_issue = (r_wait == 3'd0);
                    if (r_wait == WaitMax) begin
                        w_wait_next = '0;
                        if (r_beat == LastBeat) w_state_next = DRAIN;
                        else                    w_beat_next  = r_beat + 1'b1;
                    end else begin
                        w_wait_next = r_wait + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_load_out   = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The output line is loaded on entry to RESP so data is valid alongside the strobe;
    // the RAM still holds the last word then, whatever the wait-state count.
    always_comb begin
        w_line_final                    = r_line_buf;
        w_line_final[LineSize-32 +: 32] = w_ram_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_line      <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_line_buf  <= '0;
            r_read_data <= '0;
        end else begin
            if (w_latch) r_line <= w_req_line;
            r_beat      <= w_beat_next;
            r_wait      <= w_wait_next;
            r_cap_valid <= w_issue;
            r_cap_idx   <= r_beat;
            if (r_cap_valid) r_line_buf[{r_cap_idx, 5'd0} +: 32] <= w_ram_rdata;
            if (w_load_out)  r_read_data <= w_line_final;
        end
    end

    word_ram #(
        .DepthWords (DepthWords),
        .AddrBits   (AddrBits)
    ) u_word_ram (
        .i_clk   (clk_i),
        .i_re    (w_issue),
        .i_raddr ({r_line, r_beat}),
        .o_rdata (w_ram_rdata),
        .i_we    (wr_en_i),
        .i_waddr (wr_addr_i[AddrBits+1:2]),
        .i_wdata (wr_data_i)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency, wait states, aborts, write collision, reset.
// Two instances share clock, reset and preload port: one with 0 and one with 2 wait states.
module tb_mem_line_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        en0, en2, valid0, valid2;
    logic [31:0] addr0, addr2;
    line_t       data0, data2;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_line_responder #(.WaitStates(0)) u_dut0 (
        .clk_i (clk), .rstn_i (rstn_i),
        .mem_addr_i (addr0), .mem_read_en_i (en0),
        .mem_read_valid_o (valid0), .mem_read_data_o (data0),
        .wr_en_i (wr_en), .wr_addr_i (wr_addr), .wr_data_i (wr_data)
    );

    mem_line_responder #(.WaitStates(2)) u_dut2 (
        .clk_i (clk), .rstn_i (rstn_i),
        .mem_addr_i (addr2), .mem_read_en_i (en2),
        .mem_read_valid_o (valid2), .mem_read_data_o (data2),
        .wr_en_i (wr_en), .wr_addr_i (wr_addr), .wr_data_i (wr_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic en, input logic [31:0] a);
        if (sel) begin en2 = en; addr2 = a; end
        else     begin en0 = en; addr0 = a; end
    endtask

    function automatic logic got_valid(input bit sel);
        return sel ? valid2 : valid0;
    endfunction

    function automatic line_t got_data(input bit sel);
        return sel ? data2 : data0;
    endfunction

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic sample(input bit sel, inout int strobes);
        @(negedge clk);
        if (got_valid(sel)) strobes++;
        step();
    endtask

    // Holds the current request until the strobe, checks it lasts one cycle, then drops it.
    task automatic wait_strobe(input bit sel, input int budget, output int cyc, output line_t data);
        cyc  = -1;
        data = '0;
        for (int n = 0; n <= budget; n++) begin
            @(negedge clk);
            if (got_valid(sel)) begin
                cyc  = n;
                data = got_data(sel);
                step();
                break;
            end
            step();
        end
        if (cyc >= 0) begin
            @(negedge clk);
            check("strobe_one_cycle", 128'(got_valid(sel)), 128'd0);
            step();
        end
        drive(sel, 1'b0, sel ? addr2 : addr0);
        repeat (3) step();
    endtask

    initial begin
        int    cyc, strobes;
        line_t d;
        line_t line40, line80, line100, line_col;
        line40   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        line80   = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        line100  = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
        line_col = {32'hDEADBEEF, 32'h33333333, 32'h22222222, 32'h11111111};

        rstn_i = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        en0 = 1'b0; en2 = 1'b0; addr0 = '0; addr2 = '0;
        #12;
        check("reset_valid0", 128'(valid0), 128'd0);
        check("reset_data0", data0, 128'd0);
        check("reset_valid2", 128'(valid2), 128'd0);
        check("reset_data2", data2, 128'd0);
        @(negedge clk) rstn_i = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            write_word(32'h40 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
            write_word(32'h80 + 32'(4 * i), 32'hA0000000 + 32'(i));
            write_word(32'h100 + 32'(4 * i), 32'hC0000000 + 32'(i));
        end
        step();

        // Basic fetch: offset bits of the request address are ignored.
        drive(0, 1'b1, 32'h48);
        wait_strobe(0, 20, cyc, d);
        check("basic_latency", 128'(cyc), 128'd6);
        check("basic_data", d, line40);

        // Two wait states per beat.
        drive(1, 1'b1, 32'h40);
        wait_strobe(1, 30, cyc, d);
        check("ws2_latency", 128'(cyc), 128'd14);
        check("ws2_data", d, line40);

        // Drop in FETCH cycle 2, re-raise at 0x80 the next cycle.
        strobes = 0;
        drive(0, 1'b1, 32'h40);
        sample(0, strobes);
        sample(0, strobes);
        drive(0, 1'b0, 32'h40);
        sample(0, strobes);
        drive(0, 1'b1, 32'h80);
        wait_strobe(0, 20, cyc, d);
        check("abort_no_strobe", 128'(strobes), 128'd0);
        check("abort_relatency", 128'(cyc), 128'd6);
        check("abort_data", d, line80);

        // Address change mid-FETCH with enable held high.
        strobes = 0;
        drive(0, 1'b1, 32'h40);
        sample(0, strobes);
        sample(0, strobes);
        drive(0, 1'b1, 32'h100);
        sample(0, strobes);
        wait_strobe(0, 20, cyc, d);
        check("addrchg_no_strobe", 128'(strobes), 128'd0);
        check("addrchg_latency", 128'(cyc), 128'd6);
        check("addrchg_data", d, line100);

        // Write to word 3 in the acceptance cycle lands before its read issue.
        strobes = 0;
        drive(0, 1'b1, 32'h40);
        wr_en = 1'b1; wr_addr = 32'h4C; wr_data = 32'hDEADBEEF;
        sample(0, strobes);
        wr_en = 1'b0;
        wait_strobe(0, 20, cyc, d);
        check("collide_latency", 128'(cyc), 128'd5);
        check("collide_data", d, line_col);

        // Asynchronous reset mid-FETCH.
        drive(0, 1'b1, 32'h80);
        step();
        step();
        #2 rstn_i = 1'b0;
        #1;
        check("rst_mid_valid", 128'(valid0), 128'd0);
        check("rst_mid_data", data0, 128'd0);
        drive(0, 1'b0, 32'h80);
        @(negedge clk);
        check("rst_hold_valid", 128'(valid0), 128'd0);
        rstn_i = 1'b1;
        step();
        drive(0, 1'b1, 32'h80);
        wait_strobe(0, 20, cyc, d);
        check("rst_after_latency", 128'(cyc), 128'd6);
        check("rst_after_data", d, line80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
